// File: rtl/debug_trace_capture.sv
// Triggered trace buffer behind the SNN debug mux.
// Captures DEPTH strobed samples after a trigger, then drains via pops.
module debug_trace_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic                  sample_strobe,
  input  logic [DATA_WIDTH-1:0] debug_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   level,
  output logic [1:0]            state,
  output logic                  rd_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_LAST =
    (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_count;
  logic [DATA_WIDTH-1:0]   r_rd_data;
  logic                    r_rd_valid;
  logic                    r_rd_err;

  logic w_match;
  logic w_we;
  logic w_pop;

  assign w_match = !trig_en || (debug_data == trig_value);

  // arm and rst both suppress any write or pop in their cycle
  assign w_we = !rst && !arm && sample_strobe &&
                ((r_state == S_ARMED && w_match) ||
                 r_state == S_CAPTURE);

  assign w_pop = !rst && !arm && rd_en &&
                 (r_state == S_DONE) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr] <= debug_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (arm) begin
        r_state  <= S_ARMED;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_rd_err <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_ARMED: begin
            if (w_we) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
              r_state  <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (w_we) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
              if (r_count == LP_LAST) r_state <= S_DONE;
            end
          end
          S_DONE: begin
            if (w_pop) begin
              r_rd_data  <= r_mem[r_rd_ptr];
              r_rd_ptr   <= r_rd_ptr + 1'b1;
              r_count    <= r_count - 1'b1;
              r_rd_valid <= 1'b1;
            end else if (rd_en) begin
              r_rd_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign level    = r_count;
  assign state    = r_state;
  assign rd_err   = r_rd_err;

endmodule

// File: doc/debug_trace_capture.md
# debug_trace_capture

Triggered trace buffer that sits directly downstream of the SNN debug output multiplexer. It samples the selected 8-bit debug word once per network time step, optionally waiting for a trigger match. It stores a fixed window of DEPTH consecutive samples and then lets the host drain them through a pop interface. This lets a slow host inspect membrane-potential or spike traces that change faster than it can poll.

## Interface
- DATA_WIDTH, 8, width of captured debug word
- DEPTH, 16, samples per capture window; power of two, ≥2
- ADDR_WIDTH, 4, log2(DEPTH)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- arm  in  1  one-cycle pulse: clear buffer and (re)start a capture
- trig_en  in  1  1: wait for trig_value match; 0: start on first strobe
- trig_value  in  DATA_WIDTH  trigger compare value
- sample_strobe  in  1  one-cycle pulse per SNN time step; debug_data valid this cycle
- debug_data  in  DATA_WIDTH  output of debug mux
- rd_en  in  1  pop request; honoured only in DONE
- rd_data  out  DATA_WIDTH  popped sample, registered
- rd_valid  out  1  one-cycle pulse, rd_data valid
- level  out  ADDR_WIDTH+1  samples currently stored (0..DEPTH)
- state  out  2  IDLE=00, ARMED=01, CAPTURE=10, DONE=11
- rd_err  out  1  sticky: pop attempted with level==0 in DONE; cleared by arm/rst

## Operation
- Storage: DEPTH×DATA_WIDTH memory, write pointer, read pointer, count. Pointers wrap modulo DEPTH. level equals count.
- IDLE:
  - arm → ARMED; pointers, count and rd_err cleared.
  - Strobes and rd_en ignored.
- ARMED:
  - On sample_strobe with trig_en==0, or with debug_data==trig_value, the sample is written as entry 0 and the state moves to CAPTURE.
  - Non-matching strobes are discarded.
  - arm → stays ARMED, buffer cleared again.
- CAPTURE:
  - Each sample_strobe writes debug_data and increments count. The trigger is not re-evaluated.
  - The write that makes count==DEPTH moves the state to DONE in the same edge.
  - arm → ARMED with buffer cleared; the strobe in that cycle is not written.
- DONE:
  - sample_strobe ignored (no overwrite, no wrap of write pointer).
  - rd_en with count>0: rd_data←mem[rd_ptr], rd_ptr++, count--, rd_valid=1 next cycle.
  - rd_en with count==0: rd_valid=0, rd_err←1.
  - The state remains DONE after draining; only arm leaves it, going to ARMED with buffer cleared.
  - arm and rd_en in the same cycle: arm wins, no pop, rd_valid=0.
- rd_en outside DONE: no effect, rd_err unchanged.
- Samples are read out in capture order: the trigger sample first.

## Timing
- Reset (synchronous, rst high at edge) values:
  - state=IDLE, level=0, rd_data=0, rd_valid=0, rd_err=0.
  - Memory contents undefined.
  - rst overrides arm and all other inputs, including mid-capture or mid-drain.
- arm sampled at edge N → state=ARMED visible after edge N. A strobe coincident with arm in IDLE or ARMED is not captured.
- A strobe at edge N in ARMED/CAPTURE → level updated after edge N. The first strobe after arm can be captured one cycle after arm.
- Capture of DEPTH samples requires exactly DEPTH qualifying strobes: 1 trigger + DEPTH−1 following.
- Pop latency is 1 cycle: rd_en at edge N → rd_data/rd_valid valid after edge N, for one cycle.
  - Back-to-back rd_en every cycle drains at 1 sample/cycle.
  - rd_data holds its last value when rd_valid=0.
- Trigger compare is combinational on debug_data at the strobe edge; no pipeline.

## Test plan
- Reset mid-capture: arm, trig_en=0, 5 strobes with data 1..5, then rst → state=00, level=0, rd_valid=0; rd_en afterwards gives no rd_valid.
- Free-run capture: arm, trig_en=0, 16 strobes with data 0x10..0x1F → state=11 after the 16th; 16 back-to-back rd_en yield rd_data 0x10..0x1F on consecutive cycles; level 16→0.
- Trigger match: trig_en=1, trig_value=0x2A; strobes 0x01,0x05,0x2A,0x2B… → first stored/popped sample is 0x2A; the two pre-trigger samples are absent.
- Ignore when full: after DONE, 3 more strobes with 0xFF → level stays 16, popped data unchanged.
- Underflow: drain all 16, one more rd_en → rd_valid=0, rd_err=1; then arm → rd_err=0, state=01.
- Re-arm priority: in CAPTURE with level=7, assert arm together with a strobe (0x77) → state=01, level=0, 0x77 not stored. In DONE, arm together with rd_en → no rd_valid, level=0.
